tradeoff_pattern_driver: RTL and testbench

- On-chip initiator for the Tradeoff search core's W/N/found interface: the stimulus and check side that the simulation bench currently provides.
- Stores up to DEPTH W patterns and applies them one at a time to the core. For each pattern it waits for `found`, compares N against a fixed expected value, and accumulates pass/error counts.
- Sits beside the core in silicon self-test and FPGA bring-up wrappers.

---
 rtl/tradeoff_pkg.sv | 18 +
 rtl/tradeoff_pat_mem.sv | 26 ++
 rtl/tradeoff_pattern_driver.sv | 174 +++++++++++++++++
 tb/tb_tradeoff_pattern_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tradeoff_pkg.sv
// Shared constants and driver state encoding for the Tradeoff search core and its pattern driver.
package tradeoff_pkg;

    localparam int W_BITS = 69;
    localparam int N_BITS = 53;
    localparam logic [N_BITS-1:0] EXPECT_N = 53'd4503599627370495;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_GUARD,
        ST_WAIT,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } tradeoff_drv_state_t;

endpackage

// File: rtl/tradeoff_pat_mem.sv
// Pattern register file: one synchronous write port, one combinational read port.
// Read data follows i_raddr in the same cycle; no flow control.
module tradeoff_pat_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 69
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdat
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/tradeoff_pattern_driver.sv
// Applies stored W patterns to the search core, waits for found, checks N and tallies errors.
// Per pattern: 1 + GUARD + wait + 2 cycles; the core is never hurried, only timed out.
module tradeoff_pattern_driver
    import tradeoff_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pat_we,
    input  logic [AW-1:0]     pat_addr,
    input  logic [W_BITS-1:0] pat_wdata,
    input  logic [AW:0]       pat_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] W,
    input  logic              found,
    input  logic [N_BITS-1:0] N,
    output logic [AW:0]       total_cnt,
    output logic [AW:0]       err_cnt,
    output logic [AW-1:0]     first_err_idx,
    output logic              timeout_seen
);

    localparam int GW = $clog2(GUARD + 1);

    tradeoff_drv_state_t r_state, w_next;

    logic [AW:0]       r_count;
    logic [AW-1:0]     r_idx;
    logic [GW-1:0]     r_guard_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_to;
    logic              r_busy;
    logic              r_done;
    logic [W_BITS-1:0] r_w;
    logic [AW:0]       r_total;
    logic [AW:0]       r_err;
    logic [AW-1:0]     r_first;
    logic              r_to_seen;

    logic              w_mem_we;
    logic [W_BITS-1:0] w_rd_dat;
    logic [AW:0]       w_count_clamped;
    logic              w_to_hit;
    logic              w_last;
    logic              w_fail;

    assign w_mem_we        = pat_we && (r_state == ST_IDLE);
    assign w_count_clamped = (pat_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : pat_count;
    assign w_to_hit        = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_last          = ({1'b0, r_idx} == (r_count - (AW+1)'(1)));
    assign w_fail          = r_to || (N != EXPECT_N);

    tradeoff_pat_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (W_BITS)
    ) u_pat_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (pat_addr),
        .i_wdat  (pat_wdata),
        .i_raddr (r_idx),
        .o_rdat  (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = (w_count_clamped == '0) ? ST_DONE : ST_APPLY;
            ST_APPLY:  w_next = ST_GUARD;
            ST_GUARD:  if (r_guard_cnt <= GW'(1)) w_next = ST_WAIT;
            // A found arriving on the timeout cycle still counts as found.
            ST_WAIT: begin
                if (found) begin
                    w_next = ST_SETTLE;
                end else if (w_to_hit) begin
                    w_next = ST_CHECK;
                end
            end
            ST_SETTLE: w_next = ST_CHECK;
            ST_CHECK:  w_next = w_last ? ST_DONE : ST_APPLY;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_w         <= '0;
            r_total     <= '0;
            r_err       <= '0;
            r_first     <= '0;
            r_to_seen   <= 1'b0;
            r_count     <= '0;
            r_idx       <= '0;
            r_guard_cnt <= '0;
            r_to_cnt    <= '0;
            r_to        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count   <= w_count_clamped;
                        r_idx     <= '0;
                        r_total   <= '0;
                        r_err     <= '0;
                        r_first   <= '0;
                        r_to_seen <= 1'b0;
                        r_busy    <= (w_count_clamped != '0);
                    end
                end
                ST_APPLY: begin
                    r_w         <= w_rd_dat;
                    r_guard_cnt <= GW'(GUARD);
                    r_to        <= 1'b0;
                end
                ST_GUARD: begin
                    r_guard_cnt <= r_guard_cnt - GW'(1);
                    r_to_cnt    <= '0;
                end
                ST_WAIT: begin
                    if (!found) begin
                        if (w_to_hit) begin
                            r_to      <= 1'b1;
                            r_to_seen <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    r_total <= r_total + (AW+1)'(1);
                    if (w_fail) begin
                        r_err <= r_err + (AW+1)'(1);
                        if (r_err == '0) r_first <= r_idx;
                    end
                    if (!w_last) r_idx <= r_idx + AW'(1);
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign W             = r_w;
    assign total_cnt     = r_total;
    assign err_cnt       = r_err;
    assign first_err_idx = r_first;
    assign timeout_seen  = r_to_seen;

endmodule

// File: tb/tb_tradeoff_pattern_driver.sv
// Directed bench for tradeoff_pattern_driver with a small negedge core model.
module tb_tradeoff_pattern_driver;
    import tradeoff_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [N_BITS-1:0] BAD_N   = 53'd4503599627370494;
    localparam logic [W_BITS-1:0] GARBAGE = {5'd31, 64'hFFFF_0000_FFFF_0000};
    localparam logic [W_BITS-1:0] NEW_P0  = {5'd17, 64'h0000_0000_0000_0001};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pat_we = 1'b0;
    logic [AW-1:0]     pat_addr = '0;
    logic [W_BITS-1:0] pat_wdata = '0;
    logic [AW:0]       pat_count = '0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [W_BITS-1:0] W;
    logic              found = 1'b0;
    logic [N_BITS-1:0] N = '0;
    logic [AW:0]       total_cnt, err_cnt;
    logic [AW-1:0]     first_err_idx;
    logic              timeout_seen;

    always #5 clk = ~clk;

    tradeoff_pattern_driver dut (
        .clk(clk), .rst(rst), .pat_we(pat_we), .pat_addr(pat_addr), .pat_wdata(pat_wdata),
        .pat_count(pat_count), .start(start), .busy(busy), .done(done), .W(W),
        .found(found), .N(N), .total_cnt(total_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .timeout_seen(timeout_seen)
    );

    int total = 0;
    int bad   = 0;

    logic [W_BITS-1:0] pats [DEPTH];
    int                m_bad_idx   = -1;
    int                m_never_idx = -1;
    bit                m_stale     = 1'b0;
    logic [W_BITS-1:0] m_prev_w    = '0;
    int                m_cnt       = 0;
    int                m_wchg      = 0;

    function automatic int idx_of(input logic [W_BITS-1:0] w);
        int r = -1;
        for (int i = 0; i < DEPTH; i++) if (pats[i] === w) r = i;
        return r;
    endfunction

    // Core model: found rises 5 cycles after W changes; stale mode keeps an old found (with a wrong N) alive into GUARD.
    always @(negedge clk) begin
        int wi;
        if (W !== m_prev_w) begin
            m_prev_w = W;
            m_cnt    = 0;
            m_wchg++;
            if (m_stale) begin found = 1'b1; N = BAD_N; end
            else found = 1'b0;
        end else if (m_cnt < 1000000) begin
            m_cnt++;
        end
        wi = idx_of(W);
        if (m_stale && m_cnt == 2) found = 1'b0;
        if (m_cnt == 5 && wi != m_never_idx) begin
            found = 1'b1;
            N     = (wi == m_bad_idx) ? BAD_N : EXPECT_N;
        end
    end

    task automatic load(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            pat_we = 1'b1; pat_addr = AW'(i); pat_wdata = pats[i];
        end
        @(negedge clk);
        pat_we = 1'b0;
    endtask

    // ncyc = number of clock edges from the start edge until done is seen high.
    task automatic run_and_wait(input logic [AW:0] cnt, input bit busy_wr, input bit same_wr,
                                output int ncyc, output bit got_done);
        @(negedge clk);
        pat_count = cnt; start = 1'b1;
        if (same_wr) begin pat_we = 1'b1; pat_addr = '0; pat_wdata = NEW_P0; end
        @(negedge clk);
        start = 1'b0; pat_we = 1'b0; ncyc = 1;
        while (!done && ncyc < 20000) begin
            if (busy_wr && ncyc == 3) begin pat_we = 1'b1; pat_addr = AW'(2); pat_wdata = GARBAGE; end
            else pat_we = 1'b0;
            @(negedge clk);
            ncyc++;
        end
        pat_we   = 1'b0;
        got_done = done;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (W !== '0) begin bad++; $display("FAIL reset_W got=%h want=0", W); end
        total++; if (total_cnt !== '0) begin bad++; $display("FAIL reset_total got=%0d want=0", total_cnt); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
        total++; if (first_err_idx !== '0) begin bad++; $display("FAIL reset_first got=%0d want=0", first_err_idx); end
        total++; if (timeout_seen !== 1'b0) begin bad++; $display("FAIL reset_to_seen got=%b want=0", timeout_seen); end
        rst = 1'b0;
    endtask

    task automatic test_pass;
        int n; bit d;
        load(0, 2);
        run_and_wait(5'd3, 1'b1, 1'b0, n, d);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL pass_done got=%b want=1", d); end
        total++; if (n != 29) begin bad++; $display("FAIL pass_latency got=%0d want=29", n); end
        total++; if (total_cnt !== 5'd3) begin bad++; $display("FAIL pass_total got=%0d want=3", total_cnt); end
        total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL pass_err got=%0d want=0", err_cnt); end
        total++; if (timeout_seen !== 1'b0) begin bad++; $display("FAIL pass_to_seen got=%b want=0", timeout_seen); end
        total++; if (W !== pats[2]) begin bad++; $display("FAIL pass_busy_write_ignored got=%h want=%h", W, pats[2]); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_busy_end got=%b want=0", busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL pass_done_width got=%b want=0", done); end
    endtask

    task automatic test_mismatch;
        int n; bit d;
        m_bad_idx = 1;
        run_and_wait(5'd3, 1'b0, 1'b0, n, d);
        m_bad_idx = -1;
        total++; if (d !== 1'b1) begin bad++; $display("FAIL mis_done got=%b want=1", d); end
        total++; if (total_cnt !== 5'd3) begin bad++; $display("FAIL mis_total got=%0d want=3", total_cnt); end
        total++; if (err_cnt !== 5'd1) begin bad++; $display("FAIL mis_err got=%0d want=1", err_cnt); end
        total++; if (first_err_idx !== 4'd1) begin bad++; $display("FAIL mis_first got=%0d want=1", first_err_idx); end
    endtask

    task automatic test_timeout;
        int n; bit d;
        m_never_idx = 2;
        run_and_wait(5'd3, 1'b0, 1'b0, n, d);
        m_never_idx = -1;
        total++; if (d !== 1'b1) begin bad++; $display("FAIL to_done got=%b want=1", d); end
        total++; if (n != 4120) begin bad++; $display("FAIL to_latency got=%0d want=4120", n); end
        total++; if (total_cnt !== 5'd3) begin bad++; $display("FAIL to_total got=%0d want=3", total_cnt); end
        total++; if (err_cnt !== 5'd1) begin bad++; $display("FAIL to_err got=%0d want=1", err_cnt); end
        total++; if (first_err_idx !== 4'd2) begin bad++; $display("FAIL to_first got=%0d want=2", first_err_idx); end
        total++; if (timeout_seen !== 1'b1) begin bad++; $display("FAIL to_seen got=%b want=1", timeout_seen); end
    endtask

    task automatic test_zero_count;
        int n; bit d;
        run_and_wait(5'd0, 1'b0, 1'b0, n, d);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", d); end
        total++; if (n != 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", n); end
        total++; if (total_cnt !== 5'd0) begin bad++; $display("FAIL zero_total got=%0d want=0", total_cnt); end
        total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL zero_err_cleared got=%0d want=0", err_cnt); end
        total++; if (timeout_seen !== 1'b0) begin bad++; $display("FAIL zero_to_cleared got=%b want=0", timeout_seen); end
    endtask

    task automatic test_stale_found;
        int n, w0; bit d;
        m_stale = 1'b1;
        w0 = m_wchg;
        run_and_wait(5'd3, 1'b0, 1'b0, n, d);
        m_stale = 1'b0;
        total++; if (d !== 1'b1) begin bad++; $display("FAIL stale_done got=%b want=1", d); end
        total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL stale_err got=%0d want=0", err_cnt); end
        total++; if (total_cnt !== 5'd3) begin bad++; $display("FAIL stale_total got=%0d want=3", total_cnt); end
        total++; if (n != 29) begin bad++; $display("FAIL stale_latency got=%0d want=29", n); end
        total++; if (m_wchg - w0 != 3) begin bad++; $display("FAIL stale_w_changes got=%0d want=3", m_wchg - w0); end
    endtask

    task automatic test_clamp;
        int n; bit d;
        load(3, 15);
        run_and_wait(5'd20, 1'b0, 1'b0, n, d);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL clamp_done got=%b want=1", d); end
        total++; if (total_cnt !== 5'd16) begin bad++; $display("FAIL clamp_total got=%0d want=16", total_cnt); end
        total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL clamp_err got=%0d want=0", err_cnt); end
        total++; if (n != 146) begin bad++; $display("FAIL clamp_latency got=%0d want=146", n); end
        total++; if (W !== pats[15]) begin bad++; $display("FAIL clamp_last_W got=%h want=%h", W, pats[15]); end
    endtask

    task automatic test_mid_run_reset;
        int n, dcount; bit d;
        m_bad_idx = 0;
        @(negedge clk);
        pat_count = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        total++; if (total_cnt !== 5'd1) begin bad++; $display("FAIL mid_pre_total got=%0d want=1", total_cnt); end
        total++; if (err_cnt !== 5'd1) begin bad++; $display("FAIL mid_pre_err got=%0d want=1", err_cnt); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (W !== '0) begin bad++; $display("FAIL mid_W got=%h want=0", W); end
        total++; if (total_cnt !== '0) begin bad++; $display("FAIL mid_total got=%0d want=0", total_cnt); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL mid_err got=%0d want=0", err_cnt); end
        rst = 1'b0;
        m_bad_idx = -1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dcount); end
        run_and_wait(5'd3, 1'b0, 1'b0, n, d);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL mid_rerun_done got=%b want=1", d); end
        total++; if (n != 29) begin bad++; $display("FAIL mid_rerun_latency got=%0d want=29", n); end
        total++; if (total_cnt !== 5'd3) begin bad++; $display("FAIL mid_rerun_total got=%0d want=3", total_cnt); end
    endtask

    task automatic test_back_to_back;
        int n; bit d;
        pats[0] = NEW_P0;
        run_and_wait(5'd1, 1'b0, 1'b1, n, d);
        total++; if (d !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", d); end
        total++; if (W !== NEW_P0) begin bad++; $display("FAIL b2b_W got=%h want=%h", W, NEW_P0); end
        total++; if (total_cnt !== 5'd1) begin bad++; $display("FAIL b2b_total got=%0d want=1", total_cnt); end
        total++; if (err_cnt !== 5'd0) begin bad++; $display("FAIL b2b_err got=%0d want=0", err_cnt); end
        total++; if (n != 11) begin bad++; $display("FAIL b2b_latency got=%0d want=11", n); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) pats[i] = {5'd3, 64'hDEAD_BEEF_0000_0000 | 64'(i + 1)};
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_zero_count();
        test_stale_found();
        test_clamp();
        test_mid_run_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
